// File: rtl/fb_fill_master.sv
// fb_fill_master: fills a clipped rectangle of a 16-bit-per-pixel framebuffer
// with a constant RGB555 colour. The fill is issued as Avalon-MM word writes,
// two pixels per 32-bit word, with byte enables masking the ragged row edges.
module fb_fill_master #(
  parameter int H_PIXELS     = 640,
  parameter int V_PIXELS     = 480,
  parameter int STRIDE_BYTES = 1280
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] fbAddr,
  input  logic [9:0]  x0,
  input  logic [9:0]  y0,
  input  logic [10:0] width,
  input  logic [10:0] height,
  input  logic [14:0] color,
  output logic        busy,
  output logic        done,
  output logic [31:0] master_address,
  output logic        master_write,
  output logic [31:0] master_writedata,
  output logic [3:0]  master_byteenable,
  input  logic        master_wait_request
);

  localparam logic [11:0] H_LIM  = 12'(H_PIXELS);
  localparam logic [11:0] V_LIM  = 12'(V_PIXELS);
  localparam logic [31:0] STRIDE = 32'(STRIDE_BYTES);

  typedef enum logic [2:0] {IDLE, SETUP, WRITE, NEXT_ROW, DONE} state_t;

  // Byte enables for word idx of a row: the first and last words are masked
  // to their pixel halves; a single-word row gets both masks.
  function automatic logic [3:0] word_be(input logic [10:0] idx,
                                         input logic [10:0] nwords,
                                         input logic [3:0]  first_be,
                                         input logic [3:0]  last_be);
    logic [3:0] r;
    r = 4'b1111;
    if (idx == 11'd0) r = r & first_be;
    if (idx == nwords - 11'd1) r = r & last_be;
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] fb_q, fb_d;
  logic [9:0]  x0_q, x0_d, y0_q, y0_d;
  logic [10:0] w_q, w_d, h_q, h_d;
  logic [14:0] color_q, color_d;
  logic [31:0] row_addr_q, row_addr_d;
  logic [10:0] idx_q, idx_d, nwords_q, nwords_d;
  logic [11:0] rows_left_q, rows_left_d;
  logic [3:0]  first_be_q, first_be_d, last_be_q, last_be_d;
  logic        busy_q, busy_d, done_q, done_d, write_q, write_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;

  // Clipping geometry of the captured rectangle, consumed in SETUP.
  logic [11:0] x_sum_s, y_sum_s, eff_w_s, eff_h_s, x_end_s;
  logic [10:0] nwords_s;
  logic [3:0]  first_be_s, last_be_s;
  logic [31:0] row_start_s;
  logic        skip_s;

  // Clip the rectangle to the framebuffer and derive row word span and masks.
  always_comb begin
    x_sum_s     = {2'b00, x0_q} + {1'b0, w_q};
    y_sum_s     = {2'b00, y0_q} + {1'b0, h_q};
    eff_w_s     = (x_sum_s > H_LIM) ? (H_LIM - {2'b00, x0_q}) : {1'b0, w_q};
    eff_h_s     = (y_sum_s > V_LIM) ? (V_LIM - {2'b00, y0_q}) : {1'b0, h_q};
    x_end_s     = {2'b00, x0_q} + eff_w_s - 12'd1;
    nwords_s    = x_end_s[11:1] - {2'b00, x0_q[9:1]} + 11'd1;
    first_be_s  = x0_q[0] ? 4'b1100 : 4'b1111;
    last_be_s   = x_end_s[0] ? 4'b1111 : 4'b0011;
    row_start_s = fb_q + ({22'd0, y0_q} * STRIDE) + {21'd0, x0_q[9:1], 2'b00};
    skip_s      = ({2'b00, x0_q} >= H_LIM) || ({2'b00, y0_q} >= V_LIM) ||
                  (w_q == 11'd0) || (h_q == 11'd0);
  end

  // Next-state and next-output logic of the fill sequencer.
  always_comb begin
    state_d     = state_q;
    fb_d        = fb_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    w_d         = w_q;
    h_d         = h_q;
    color_d     = color_q;
    row_addr_d  = row_addr_q;
    idx_d       = idx_q;
    nwords_d    = nwords_q;
    rows_left_d = rows_left_q;
    first_be_d  = first_be_q;
    last_be_d   = last_be_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          fb_d    = fbAddr & 32'hFFFF_FFFC;
          x0_d    = x0;
          y0_d    = y0;
          w_d     = width;
          h_d     = height;
          color_d = color;
          busy_d  = 1'b1;
          state_d = SETUP;
        end else begin
          busy_d  = 1'b0;
        end
      end
      SETUP: begin
        if (skip_s) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d     = WRITE;
          row_addr_d  = row_start_s;
          nwords_d    = nwords_s;
          idx_d       = 11'd0;
          rows_left_d = eff_h_s;
          first_be_d  = first_be_s;
          last_be_d   = last_be_s;
          addr_d      = row_start_s;
          write_d     = 1'b1;
          wdata_d     = {1'b0, color_q, 1'b0, color_q};
          be_d        = word_be(11'd0, nwords_s, first_be_s, last_be_s);
        end
      end
      WRITE: begin
        if (!master_wait_request) begin
          if (idx_q == nwords_q - 11'd1) begin
            state_d     = NEXT_ROW;
            write_d     = 1'b0;
            row_addr_d  = row_addr_q + STRIDE;
            rows_left_d = rows_left_q - 12'd1;
          end else begin
            idx_d  = idx_q + 11'd1;
            addr_d = addr_q + 32'd4;
            be_d   = word_be(idx_q + 11'd1, nwords_q, first_be_q, last_be_q);
          end
        end else begin
          write_d = 1'b1;
        end
      end
      NEXT_ROW: begin
        if (rows_left_q == 12'd0) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = WRITE;
          idx_d   = 11'd0;
          addr_d  = row_addr_q;
          write_d = 1'b1;
          be_d    = word_be(11'd0, nwords_q, first_be_q, last_be_q);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      fb_q        <= 32'd0;
      x0_q        <= 10'd0;
      y0_q        <= 10'd0;
      w_q         <= 11'd0;
      h_q         <= 11'd0;
      color_q     <= 15'd0;
      row_addr_q  <= 32'd0;
      idx_q       <= 11'd0;
      nwords_q    <= 11'd0;
      rows_left_q <= 12'd0;
      first_be_q  <= 4'd0;
      last_be_q   <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
    end else begin
      state_q     <= state_d;
      fb_q        <= fb_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      w_q         <= w_d;
      h_q         <= h_d;
      color_q     <= color_d;
      row_addr_q  <= row_addr_d;
      idx_q       <= idx_d;
      nwords_q    <= nwords_d;
      rows_left_q <= rows_left_d;
      first_be_q  <= first_be_d;
      last_be_q   <= last_be_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign master_address    = addr_q;
  assign master_write      = write_q;
  assign master_writedata  = wdata_q;
  assign master_byteenable = be_q;

endmodule

// File: tb/tb_fb_fill_master.sv
// Directed testbench for fb_fill_master with hand-computed expectations.
module tb_fb_fill_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] fbAddr;
  logic [9:0]  x0, y0;
  logic [10:0] width, height;
  logic [14:0] color;
  logic        busy, done;
  logic [31:0] master_address;
  logic        master_write;
  logic [31:0] master_writedata;
  logic [3:0]  master_byteenable;
  logic        wait_req;

  int tests = 0;
  int fails = 0;
  int accepted = 0;
  int acc_base;

  fb_fill_master #(.H_PIXELS(640), .V_PIXELS(480), .STRIDE_BYTES(1280)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .fbAddr              (fbAddr),
    .x0                  (x0),
    .y0                  (y0),
    .width               (width),
    .height              (height),
    .color               (color),
    .busy                (busy),
    .done                (done),
    .master_address      (master_address),
    .master_write        (master_write),
    .master_writedata    (master_writedata),
    .master_byteenable   (master_byteenable),
    .master_wait_request (wait_req)
  );

  always #5 clk = ~clk;

  // Count writes accepted by the slave.
  always @(posedge clk) begin
    if (!rst && master_write && !wait_req) accepted <= accepted + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] d);
    chk({tag, "_wr"}, {31'd0, master_write}, 32'd1);
    chk({tag, "_addr"}, master_address, a);
    chk({tag, "_be"}, {28'd0, master_byteenable}, {28'd0, be});
    chk({tag, "_data"}, master_writedata, d);
  endtask

  task automatic set_req(input logic [31:0] fb, input logic [9:0] x, input logic [9:0] y,
                         input logic [10:0] w, input logic [10:0] h, input logic [14:0] c);
    fbAddr = fb; x0 = x; y0 = y; width = w; height = h; color = c;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; wait_req = 1'b0;
    set_req(32'd0, 10'd0, 10'd0, 11'd0, 11'd0, 15'd0);
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_write", {31'd0, master_write}, 32'd0);
    chk("rst_addr", master_address, 32'd0);
    chk("rst_data", master_writedata, 32'd0);
    chk("rst_be", {28'd0, master_byteenable}, 32'd0);
    tick;

    // Basic 4-pixel single-row fill; start on the first edge after reset release.
    rst = 1'b0;
    set_req(32'h1000, 10'd0, 10'd0, 11'd4, 11'd1, 15'h7FFF);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("t1_setup_busy", {31'd0, busy}, 32'd1);
    chk("t1_setup_wr", {31'd0, master_write}, 32'd0);
    tick; chk_wr("t1_w0", 32'h1000, 4'b1111, 32'h7FFF7FFF);
    tick; chk_wr("t1_w1", 32'h1004, 4'b1111, 32'h7FFF7FFF);
    tick;
    chk("t1_nr_wr", {31'd0, master_write}, 32'd0);
    chk("t1_nr_busy", {31'd0, busy}, 32'd1);
    tick;
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_done_busy", {31'd0, busy}, 32'd0);
    tick;
    chk("t1_done_pulse", {31'd0, done}, 32'd0);

    // Odd x0, two rows, partial words at both row ends.
    set_req(32'd0, 10'd1, 10'd2, 11'd2, 11'd2, 15'h03E0);
    start = 1'b1;
    tick;
    start = 1'b0;
    tick; chk_wr("t2_r0w0", 32'h0A00, 4'b1100, 32'h03E003E0);
    tick; chk_wr("t2_r0w1", 32'h0A04, 4'b0011, 32'h03E003E0);
    tick; chk("t2_gap", {31'd0, master_write}, 32'd0);
    tick; chk_wr("t2_r1w0", 32'h0F00, 4'b1100, 32'h03E003E0);
    tick; chk_wr("t2_r1w1", 32'h0F04, 4'b0011, 32'h03E003E0);
    tick; chk("t2_nr", {31'd0, master_write}, 32'd0);
    tick; chk("t2_done", {31'd0, done}, 32'd1);
    tick;

    // Right-edge clipping down to a single odd pixel.
    set_req(32'd0, 10'd639, 10'd0, 11'd10, 11'd1, 15'h4A5B);
    start = 1'b1;
    tick;
    start = 1'b0;
    tick; chk_wr("t3_w0", 32'h04FC, 4'b1100, 32'h4A5B4A5B);
    tick; chk("t3_nr", {31'd0, master_write}, 32'd0);
    tick; chk("t3_done", {31'd0, done}, 32'd1);
    tick;

    // Fully clipped rectangle; start during DONE ignored, next IDLE start taken.
    set_req(32'd0, 10'd640, 10'd0, 11'd4, 11'd4, 15'h1111);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("t4_setup_busy", {31'd0, busy}, 32'd1);
    chk("t4_setup_wr", {31'd0, master_write}, 32'd0);
    tick;
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_done_wr", {31'd0, master_write}, 32'd0);
    set_req(32'd0, 10'd5, 10'd5, 11'd3, 11'd0, 15'h2222);
    start = 1'b1;
    tick;
    chk("t4_start_in_done", {31'd0, busy}, 32'd0);
    tick;
    start = 1'b0;
    chk("t4_start_in_idle", {31'd0, busy}, 32'd1);
    tick;
    chk("t4_h0_done", {31'd0, done}, 32'd1);
    chk("t4_h0_wr", {31'd0, master_write}, 32'd0);
    tick;

    // Wait-state stall on the second word, start pulsed while busy.
    acc_base = accepted;
    set_req(32'h2000, 10'd0, 10'd1, 11'd6, 11'd1, 15'h001F);
    start = 1'b1;
    tick;
    start = 1'b0;
    tick; chk_wr("t5_w0", 32'h2500, 4'b1111, 32'h001F001F);
    tick; chk_wr("t5_w1", 32'h2504, 4'b1111, 32'h001F001F);
    wait_req = 1'b1;
    set_req(32'd0, 10'd0, 10'd0, 11'd8, 11'd8, 15'h7C00);
    start = 1'b1;
    tick; chk_wr("t5_stall1", 32'h2504, 4'b1111, 32'h001F001F);
    start = 1'b0;
    tick; chk_wr("t5_stall2", 32'h2504, 4'b1111, 32'h001F001F);
    tick; chk_wr("t5_stall3", 32'h2504, 4'b1111, 32'h001F001F);
    wait_req = 1'b0;
    tick; chk_wr("t5_w2", 32'h2508, 4'b1111, 32'h001F001F);
    tick; chk("t5_nr", {31'd0, master_write}, 32'd0);
    tick; chk("t5_done", {31'd0, done}, 32'd1);
    tick; chk("t5_ignored_busy", {31'd0, busy}, 32'd0);
    tick; chk("t5_still_idle", {31'd0, busy}, 32'd0);
    chk("t5_accepts", 32'(accepted - acc_base), 32'd3);

    // Asynchronous reset mid-row, then a fresh fill.
    set_req(32'd0, 10'd0, 10'd0, 11'd8, 11'd2, 15'h7C00);
    start = 1'b1;
    tick;
    start = 1'b0;
    tick; chk_wr("t6_w0", 32'h0000, 4'b1111, 32'h7C007C00);
    tick; chk_wr("t6_w1", 32'h0004, 4'b1111, 32'h7C007C00);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_wr", {31'd0, master_write}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_addr", master_address, 32'd0);
    chk("t6_rst_be", {28'd0, master_byteenable}, 32'd0);
    tick;
    rst = 1'b0;
    set_req(32'h0100, 10'd2, 10'd0, 11'd1, 11'd1, 15'h7C00);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("t6_restart_busy", {31'd0, busy}, 32'd1);
    tick; chk_wr("t6_r_w0", 32'h0104, 4'b0011, 32'h7C007C00);
    tick; chk("t6_r_nr", {31'd0, master_write}, 32'd0);
    tick; chk("t6_r_done", {31'd0, done}, 32'd1);
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fb_fill_master.md
FB_FILL_MASTER -- requirements
Module: fb_fill_master

Interface
REQ-001 SHALL have parameter H_PIXELS, default 640: framebuffer width in pixels.
REQ-002 SHALL have parameter V_PIXELS, default 480: framebuffer height in pixels.
REQ-003 SHALL have parameter STRIDE_BYTES, default 1280: byte distance between framebuffer rows.
REQ-004 SHALL have port clk, input, 1: system clock; all logic is in this single domain.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port start, input, 1: one-cycle request to begin a fill.
REQ-007 SHALL have port fbAddr, input, 32: framebuffer base byte address; bits [1:0] are ignored and treated as 0.
REQ-008 SHALL have port x0, input, 10: left pixel column of the rectangle.
REQ-009 SHALL have port y0, input, 10: top pixel row of the rectangle.
REQ-010 SHALL have port width, input, 11: rectangle width in pixels.
REQ-011 SHALL have port height, input, 11: rectangle height in pixels.
REQ-012 SHALL have port color, input, 15: RGB555 fill colour, R=[14:10], G=[9:5], B=[4:0].
REQ-013 SHALL have port busy, output, 1: high from the cycle after an accepted start until done.
REQ-014 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-015 SHALL have port master_address, output, 32: Avalon-MM word-aligned byte address.
REQ-016 SHALL have port master_write, output, 1: Avalon-MM write request.
REQ-017 SHALL have port master_writedata, output, 32: Avalon-MM write data.
REQ-018 SHALL have port master_byteenable, output, 4: Avalon-MM byte enables.
REQ-019 SHALL have port master_wait_request, input, 1: Avalon-MM stall; a write completes on a cycle where master_write=1 and master_wait_request=0.

Function
REQ-020 SHALL implement the states IDLE, SETUP, WRITE, NEXT_ROW and DONE.
REQ-021 In IDLE, start=1 SHALL capture fbAddr, x0, y0, width, height and color, then enter SETUP on the next edge.
REQ-022 start SHALL be ignored in every state other than IDLE.
REQ-023 SETUP SHALL take one cycle and clip the rectangle: if x0>=H_PIXELS, y0>=V_PIXELS, width=0 or height=0, go to DONE with no writes.
REQ-024 SETUP SHALL clip the extent: if x0+width>H_PIXELS, the effective width is H_PIXELS-x0, with 12-bit sums so no overflow; height is clipped to V_PIXELS-y0 the same way.
REQ-025 Pixels SHALL be 16-bit, two per 32-bit word: even x occupies [15:0], odd x occupies [31:16].
REQ-026 master_writedata SHALL be {1'b0,color,1'b0,color} for every write.
REQ-027 Word address SHALL be fbAddr + y*STRIDE_BYTES + (x>>1)*4, computed without truncation in 32 bits.
REQ-028 Each row SHALL be written left to right, one word per accepted write, with no duplicated or skipped words.
REQ-029 The first word of a row SHALL have byteenable 1100 when x0 is odd, else 1111.
REQ-030 The last word of a row SHALL have byteenable 0011 when the last pixel column is even, else 1111.
REQ-031 A single-word row SHALL use the AND of the first-word and last-word enables; for example, one pixel at odd x gives 1100.
REQ-032 master_write SHALL first assert two cycles after the edge at which start is sampled.
REQ-033 While master_wait_request=1, master_address, master_writedata and master_byteenable SHALL be held stable and master_write SHALL stay high.
REQ-034 In WRITE, back-to-back accepted writes SHALL issue one word per cycle.
REQ-035 After the last word of a row is accepted, the block SHALL spend one cycle in NEXT_ROW with master_write=0, then resume at the next row, or go to DONE after the last row.
REQ-036 DONE SHALL last one cycle, with done=1 and busy=0, and then return to IDLE.
REQ-037 A start arriving in the DONE cycle SHALL be ignored; a start in the following IDLE cycle SHALL be accepted.
REQ-038 master_write SHALL be 0 in IDLE, SETUP, NEXT_ROW and DONE.

Reset
REQ-039 rst=1 SHALL immediately force state=IDLE, busy=0, done=0, master_write=0, master_address=0, master_writedata=0 and master_byteenable=0, including mid-write.
REQ-040 After rst is released, the block SHALL accept start on the first clk edge.

Verification
REQ-041 fbAddr=0x1000, x0=0, y0=0, width=4, height=1, color=0x7FFF, wait_request=0 -> writes 0x1000 and 0x1004, be 1111, data 0x7FFF7FFF, done 5 cycles after start.
REQ-042 x0=1, y0=2, width=2, height=2, fbAddr=0 -> writes 0xA00/1100, 0xA04/0011, NEXT_ROW gap, 0xF00/1100, 0xF04/0011.
REQ-043 x0=639, width=10, height=1, y0=0 -> single write at 0x4FC, be 1100, then done.
REQ-044 x0=640 or height=0 -> no writes, done pulses 2 cycles after start.
REQ-045 wait_request held high for 3 cycles on the second word -> address, data and be stable for 4 cycles, no duplicate write; start pulsed while busy -> ignored.
REQ-046 rst asserted mid-row -> master_write=0 and busy=0 in the same cycle; a new start after release fills correctly.
